// File: rtl/master_req_queue_if.sv
// Bundles the core-side and crossbar-side signals of master_req_queue.
// The slave modport is the queue's own view. The master modport is the view of
// the environment around it, meaning the core plus the crossbar port.
interface master_req_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  // Core -> queue transaction channel
  logic              in_valid;
  logic              in_ready;
  logic              in_cmd;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;

  // Queue -> core response channel
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_cmd;
  logic [DATA_W-1:0] resp_rdata;

  // Queue <-> crossbar master port
  logic              master_req;
  logic              master_cmd;
  logic [ADDR_W-1:0] master_addr;
  logic [DATA_W-1:0] master_wdata;
  logic              master_ack;
  logic [DATA_W-1:0] master_rdata;

  // Status
  logic [CNT_W-1:0]  count;
  logic              busy;

  modport slave (
    input  in_valid, in_cmd, in_addr, in_wdata,
    input  resp_ready,
    input  master_ack, master_rdata,
    output in_ready,
    output resp_valid, resp_cmd, resp_rdata,
    output master_req, master_cmd, master_addr, master_wdata,
    output count, busy
  );

  modport master (
    output in_valid, in_cmd, in_addr, in_wdata,
    output resp_ready,
    output master_ack, master_rdata,
    input  in_ready,
    input  resp_valid, resp_cmd, resp_rdata,
    input  master_req, master_cmd, master_addr, master_wdata,
    input  count, busy
  );
endinterface

// File: rtl/master_req_queue.sv
// Master-side request queue sitting in front of one crossbar master port.
// Core transactions are buffered in a FIFO and issued to the crossbar one at a
// time. Exactly one response per transaction is returned to the core, in
// order. At most one transaction is ever outstanding.
module master_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic                clk,
  input logic                reset,
  master_req_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // FIFO storage and bookkeeping
  logic              mem_cmd   [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;

  // Response holding register
  logic              resp_valid_q;
  logic              resp_cmd_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic push;
  logic pop;
  logic head_cmd;
  logic ack_in_req;

  // A full queue never accepts, even if the head pops in the same cycle.
  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign ack_in_req   = (state_q == REQ) && bus.master_ack;
  assign pop          = ack_in_req;
  assign head_cmd     = mem_cmd[rd_ptr];

  // Payload storage: capture the incoming transaction at the write pointer.
  // NOTE: the payload array is deliberately not reset. Only the pointers and
  // count need a known value. Head contents are never acted on while count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[wr_ptr]   <= bus.in_cmd;
      mem_addr[wr_ptr]  <= bus.in_addr;
      mem_wdata[wr_ptr] <= bus.in_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. Count tracks push/pop.
  // NOTE: sequential state uses non-blocking assignments only. That way every
  // flop samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register; reset drops any in-flight transaction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. IDLE also reacts to a push arriving into an empty queue.
  // This gives the one-cycle push-to-request latency. master_req still comes
  // purely from the registered state.
  // NOTE: state_d gets its default before the case. Every path then assigns
  // it, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (((count_q != '0) || push) && !resp_valid_q) state_d = REQ;
      end
      REQ: begin
        if (bus.master_ack) state_d = head_cmd ? IDLE : RDATA;
      end
      RDATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response register: load on write ack or read data capture, clear on consume.
  // Loads only happen with resp_valid low, so a held response is never overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_cmd_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      if (resp_valid_q && bus.resp_ready) resp_valid_q <= 1'b0;
      if (ack_in_req) begin
        resp_cmd_q <= head_cmd;
        if (head_cmd) begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
      end
      if (state_q == RDATA) begin
        resp_valid_q <= 1'b1;
        resp_cmd_q   <= 1'b0;
        resp_rdata_q <= bus.master_rdata;
      end
    end
  end

  assign bus.master_req   = (state_q == REQ);
  assign bus.master_cmd   = head_cmd;
  assign bus.master_addr  = mem_addr[rd_ptr];
  assign bus.master_wdata = mem_wdata[rd_ptr];

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_cmd     = resp_cmd_q;
  assign bus.resp_rdata   = resp_rdata_q;

  assign bus.count        = count_q;
  assign bus.busy         = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_master_req_queue.sv
// Self-checking bench for master_req_queue. It runs directed sequences and a
// vector table, then random traffic checked against a transaction-level model.
module tb_master_req_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  master_req_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

  master_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_cmd;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        cmd;
    logic [31:0] rdata;
  } rsp_t;

  vec_t vecs [10];
  txn_t mq [$];
  rsp_t rq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_cmd       = 1'b0;
    bus.in_addr      = '0;
    bus.in_wdata     = '0;
    bus.resp_ready   = 1'b0;
    bus.master_ack   = 1'b0;
    bus.master_rdata = '0;
  endtask

  task automatic push_one(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata);
    bus.in_valid = 1'b1;
    bus.in_cmd   = cmd;
    bus.in_addr  = addr;
    bus.in_wdata = wdata;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Serve the crossbar and consume responses until the queue goes quiet.
  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy && !bus.resp_valid) begin
        done = 1'b1;
        break;
      end
      bus.master_ack = bus.master_req;
      bus.resp_ready = 1'b1;
      step();
    end
    bus.master_ack = 1'b0;
    bus.resp_ready = 1'b0;
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    logic        rd_pending;
    logic [31:0] rd_val;
    logic        p, a, cns;
    txn_t        t;

    // Vector table: ten alternating transactions through a 4-deep queue, so
    // the pointers wrap. Writes respond with rdata 0. Reads respond with the
    // data beat.
    vecs[0] = '{1'b1, 32'h3000_0000, 32'hA5A5_0001, 0, 32'h0,         1'b1, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0010, 32'h0,         1, 32'hC0DE_0001, 1'b0, 32'hC0DE_0001};
    vecs[2] = '{1'b1, 32'h3000_0020, 32'hA5A5_0002, 2, 32'h0,         1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h3000_0030, 32'h0,         3, 32'hC0DE_0002, 1'b0, 32'hC0DE_0002};
    vecs[4] = '{1'b1, 32'h3000_0040, 32'hA5A5_0003, 3, 32'h0,         1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h3000_0050, 32'h0,         0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    vecs[6] = '{1'b1, 32'h3000_0060, 32'hA5A5_0004, 1, 32'h0,         1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'h3000_0070, 32'h0,         2, 32'h0000_0001, 1'b0, 32'h0000_0001};
    vecs[8] = '{1'b1, 32'h3000_0080, 32'hA5A5_0005, 0, 32'h0,         1'b1, 32'h0};
    vecs[9] = '{1'b0, 32'h3000_0090, 32'h0,         1, 32'h8765_4321, 1'b0, 32'h8765_4321};

    // ---------------- reset state ----------------
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_master_req", 32'(bus.master_req), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_cmd",   32'(bus.resp_cmd),   32'd0);
    check("rst_resp_rdata", bus.resp_rdata,      32'd0);
    check("rst_count",      32'(bus.count),      32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    step();
    step();
    reset = 1'b0;
    step();

    // ---------------- single write ----------------
    push_one(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    check("wr_req",   32'(bus.master_req), 32'd1);
    check("wr_cmd",   32'(bus.master_cmd), 32'd1);
    check("wr_addr",  bus.master_addr,     32'h8000_0010);
    check("wr_wdata", bus.master_wdata,    32'hDEAD_BEEF);
    check("wr_count", 32'(bus.count),      32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wr_req_hold",  32'(bus.master_req), 32'd1);
      check("wr_addr_hold", bus.master_addr,     32'h8000_0010);
    end
    bus.master_ack = 1'b1;
    step();
    bus.master_ack = 1'b0;
    check("wr_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("wr_resp_cmd",   32'(bus.resp_cmd),   32'd1);
    check("wr_resp_rdata", bus.resp_rdata,      32'd0);
    check("wr_count_end",  32'(bus.count),      32'd0);
    check("wr_req_drop",   32'(bus.master_req), 32'd0);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("wr_resp_consumed", 32'(bus.resp_valid), 32'd0);

    // ---------------- single read ----------------
    push_one(1'b0, 32'h0000_0004, 32'h0);
    check("rd_req",  32'(bus.master_req), 32'd1);
    check("rd_cmd",  32'(bus.master_cmd), 32'd0);
    check("rd_addr", bus.master_addr,     32'h0000_0004);
    bus.master_ack = 1'b1;
    step();
    bus.master_ack = 1'b0;
    check("rd_req_rdata_phase", 32'(bus.master_req), 32'd0);
    check("rd_resp_not_yet",    32'(bus.resp_valid), 32'd0);
    bus.master_rdata = 32'h1234_5678;
    step();
    bus.master_rdata = '0;
    check("rd_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("rd_resp_cmd",   32'(bus.resp_cmd),   32'd0);
    check("rd_resp_rdata", bus.resp_rdata,      32'h1234_5678);
    check("rd_busy_idle",  32'(bus.busy),       32'd0);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;

    // ---------------- fill, then response backpressure ----------------
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_cmd   = 1'b1;
      bus.in_addr  = 32'h0000_0100 + 32'(k * 4);
      bus.in_wdata = 32'(k);
      if (k == 4) begin
        check("fill_in_ready_full", 32'(bus.in_ready), 32'd0);
        check("fill_count_full",    32'(bus.count),    32'd4);
      end else begin
        check("fill_in_ready", 32'(bus.in_ready), 32'd1);
      end
      step();
    end
    bus.in_valid = 1'b0;
    check("fill_count_kept", 32'(bus.count), 32'd4);
    check("fill_head_addr",  bus.master_addr, 32'h0000_0100);
    step();
    step();
    check("fill_head_stable", bus.master_addr,     32'h0000_0100);
    check("fill_req_high",    32'(bus.master_req), 32'd1);

    bus.master_ack = 1'b1;
    step();
    bus.master_ack = 1'b0;
    check("bp_count3", 32'(bus.count), 32'd3);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("bp_gap_idle", 32'(bus.master_req), 32'd0);
    step();
    check("bp_second_req",  32'(bus.master_req), 32'd1);
    check("bp_second_addr", bus.master_addr,     32'h0000_0104);
    bus.master_ack = 1'b1;
    step();
    bus.master_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_req",   32'(bus.master_req), 32'd0);
      check("bp_hold_count", 32'(bus.count),      32'd2);
      check("bp_hold_resp",  32'(bus.resp_valid), 32'd1);
      step();
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("bp_release_c1", 32'(bus.master_req), 32'd0);
    step();
    check("bp_release_c2", 32'(bus.master_req), 32'd1);
    check("bp_third_addr", bus.master_addr,     32'h0000_0108);
    drain("bp_drain");

    // ---------------- vector table (wrap-around) ----------------
    for (int v = 0; v < 10; v++) begin
      push_one(vecs[v].cmd, vecs[v].addr, vecs[v].wdata);
      check("tbl_req",   32'(bus.master_req), 32'd1);
      check("tbl_cmd",   32'(bus.master_cmd), 32'(vecs[v].cmd));
      check("tbl_addr",  bus.master_addr,     vecs[v].addr);
      check("tbl_wdata", bus.master_wdata,    vecs[v].wdata);
      for (int d = 0; d < vecs[v].delay; d++) begin
        step();
        check("tbl_req_wait", 32'(bus.master_req), 32'd1);
      end
      bus.master_ack = 1'b1;
      step();
      bus.master_ack = 1'b0;
      check("tbl_req_after_ack", 32'(bus.master_req), 32'd0);
      if (!vecs[v].cmd) begin
        bus.master_rdata = vecs[v].rdata;
        step();
        bus.master_rdata = '0;
      end
      check("tbl_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("tbl_resp_cmd",   32'(bus.resp_cmd),   32'(vecs[v].exp_cmd));
      check("tbl_resp_rdata", bus.resp_rdata,      vecs[v].exp_rdata);
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
    end

    // ---------------- random traffic vs. transaction model ----------------
    // Model: an ordered queue of accepted transactions and an ordered queue of
    // responses owed to the core. Occupancy is the size of the first queue.
    rd_pending = 1'b0;
    for (int c = 0; c < 500; c++) begin
      bus.in_valid     = (c < 300) && ($urandom_range(0, 1) == 1);
      bus.in_cmd       = 1'($urandom_range(0, 1));
      bus.in_addr      = $urandom;
      bus.in_wdata     = $urandom;
      bus.master_ack   = ($urandom_range(0, 2) == 0);
      bus.master_rdata = $urandom;
      bus.resp_ready   = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd_count",      32'(bus.count),      32'(mq.size()));
      check("rnd_in_ready",   32'(bus.in_ready),   32'(mq.size() != DEPTH));
      check("rnd_resp_valid", 32'(bus.resp_valid), 32'(rq.size() != 0));
      if (bus.master_req) begin
        check("rnd_req_legal", 32'(mq.size() != 0 && rq.size() == 0 && !rd_pending), 32'd1);
        if (mq.size() != 0) begin
          check("rnd_master_cmd", 32'(bus.master_cmd), 32'(mq[0].cmd));
          check("rnd_master_addr", bus.master_addr, mq[0].addr);
          if (mq[0].cmd) check("rnd_master_wdata", bus.master_wdata, mq[0].wdata);
        end
      end
      p      = bus.in_valid && bus.in_ready;
      a      = bus.master_req && bus.master_ack;
      cns    = bus.resp_valid && bus.resp_ready;
      rd_val = bus.master_rdata;
      if (cns && rq.size() != 0) begin
        check("rnd_resp_cmd",   32'(bus.resp_cmd), 32'(rq[0].cmd));
        check("rnd_resp_rdata", bus.resp_rdata,    rq[0].rdata);
      end
      @(posedge clk);
      if (cns && rq.size() != 0) void'(rq.pop_front());
      if (rd_pending) begin
        rq.push_back('{1'b0, rd_val});
        rd_pending = 1'b0;
      end
      if (a && mq.size() != 0) begin
        t = mq.pop_front();
        if (t.cmd) rq.push_back('{1'b1, 32'h0});
        else       rd_pending = 1'b1;
      end
      if (p) mq.push_back('{bus.in_cmd, bus.in_addr, bus.in_wdata});
      #1;
    end
    idle_inputs();
    check("rnd_drained", 32'(mq.size() + rq.size() + int'(rd_pending)), 32'd0);
    drain("rnd_final_drain");

    // ---------------- reset mid-transaction ----------------
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_cmd   = 1'b0;
      bus.in_addr  = 32'h0000_0200 + 32'(k * 4);
      bus.in_wdata = '0;
      step();
    end
    bus.in_valid = 1'b0;
    check("mid_pre_req",   32'(bus.master_req), 32'd1);
    check("mid_pre_count", 32'(bus.count),      32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_req",      32'(bus.master_req), 32'd0);
    check("mid_rst_resp",     32'(bus.resp_valid), 32'd0);
    check("mid_rst_count",    32'(bus.count),      32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready),   32'd1);
    check("mid_rst_busy",     32'(bus.busy),       32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_no_req",  32'(bus.master_req), 32'd0);
      check("post_rst_count",   32'(bus.count),      32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
